demux_from_regs: RTL and testbench
==================================

// Module: demux_from_regs
// PURPOSE
//  Registered 1-to-4 demultiplexer: the inverse of the 4:1 gate-level select mux.
//  Accepts one data word per handshake and steers it to one of four output channels.
//  The target channel is chosen by the 2-bit select {A,B}.
//  Each channel has a one-entry holding register with its own valid/ready handshake.
//  Sits between a single producer and four independent consumers.
// PARAMETERS
//  W      8   data width of input word and of each output channel
//  CNT_W  8   width of each per-channel delivery counter (CNT feature only)
// PORTS
//  clk        in   1      single clock; all state updates on the rising edge
//  reset      in   1      asynchronous, active-high reset
//  in_valid   in   1      producer offers in_data/in_sel this cycle
//  in_ready   out  1      block can accept this cycle (combinational)
//  in_sel     in   2      {A,B}: 00->ch0, 01->ch1, 10->ch2, 11->ch3
//  in_data    in   W      word to route
//  out_valid  out  4      bit i: channel i holds a word
//  out_ready  in   4      bit i: consumer i takes the word this cycle
//  out_data   out  4*W    channel i occupies bits [i*W +: W]
//  out_cnt    out  4*CNT_W  per-channel delivered-word counters
// BEHAVIOUR
//  - Reset: all full[i]=0, so out_valid=0000, out_data=0 and out_cnt=0. The async
//    assert takes effect immediately; deassert is sampled on the next clk edge.
//  - Reset mid-transfer discards any held words. Nothing is replayed.
//  - Input acceptance: push = in_valid & in_ready.
//  - in_ready = ~full[in_sel] | out_ready[in_sel]. This depends only on the selected
//    channel; the state of other channels never stalls the input.
//  - push, sel=k: on the next edge, slot k loads in_data and full[k] becomes 1.
//    Latency is exactly 1 cycle from accept to out_valid[k].
//  - pop[i] = out_valid[i] & out_ready[i]. On the edge full[i] clears, unless the
//    same cycle also pushes to i. In that case the slot reloads with the new word
//    and full[i] stays 1, giving back-to-back throughput of 1 word/cycle/channel.
//  - Pops on different channels in the same cycle are independent. Up to 4 pops
//    plus 1 push can occur per cycle.
//  - Stall rule: while out_valid[i]=1 and out_ready[i]=0, out_data[i] is held
//    stable. in_sel and in_data are don't-care whenever in_valid=0.
//  - out_data[i] keeps its last value after a pop, which is harmless. It is only
//    meaningful while out_valid[i]=1.
//  - Per-channel state is a 2-state FSM, EMPTY<->FULL:
//    EMPTY->FULL on push;
//    FULL->EMPTY on pop without push;
//    FULL->FULL on pop+push, or on no pop.
//  - Ordering: words for the same channel arrive in acceptance order. There is no
//    ordering guarantee across channels.
// CONFIGURATION
//  - Feature macro: DEMUX_FROM_REGS_CNT_EN.
//  - With DEMUX_FROM_REGS_CNT_EN defined: each pop[i] increments out_cnt[i]
//    (CNT_W bits). The counter wraps modulo 2^CNT_W (255 -> 0 at the default width)
//    and clears on reset.
//  - Without it: out_cnt is tied to 0, no counter flops are built, and the port
//    list is unchanged.
// TESTING
//  1. Reset: assert reset mid-cycle -> out_valid=0000 immediately; out_cnt=0.
//  2. Routing: push 0xA0..0xA3 with sel 0..3 and out_ready=0000 -> out_valid=1111,
//     ch i holds 0xA0+i. Then push 0x55 to sel 2 -> in_ready=0 and ch2 stays 0xA2.
//  3. Throughput: out_ready=1111, push 0x01..0x10 all to sel 1 on consecutive
//     cycles -> in_ready stays 1; ch1 delivers 0x01..0x10 in order, 1 per cycle,
//     1-cycle latency.
//  4. Isolation: ch0 full and stalled (out_ready[0]=0); push 0x77 to sel 3 ->
//     accepted. ch3 delivers 0x77 while ch0 still holds its word.
//  5. Simultaneous: ch2 full with 0x11, out_ready[2]=1, push 0x22 to sel 2 in the
//     same cycle -> 0x11 popped, then 0x22 valid next cycle; full[2] never drops.
//  6. With DEMUX_FROM_REGS_CNT_EN: 257 pops on ch0 -> out_cnt[0]=1 (wrap); other
//     channels stay 0. Without the macro: out_cnt=0 throughout.

Source files
------------

// File: rtl/demux_from_regs_if.sv
// Handshake bundle between one producer, the demux and four consumers.
// Carries the input valid/ready/sel/data and the four output channels with their counters.
// The master modport is the producer/consumer side; the slave modport is the demux itself.
interface demux_from_regs_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_sel;
    logic [W-1:0]         in_data;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [4*W-1:0]       out_data;
    logic [4*CNT_W-1:0]   out_cnt;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/demux_from_regs.sv
// Registered 1-to-4 demux: steers each accepted word to channel in_sel via a one-entry slot.
// Latency: 1 cycle from accept to out_valid; 1 word/cycle/channel when the consumer keeps up.
// Backpressure: in_ready stalls only on the selected channel; optional counters via DEMUX_FROM_REGS_CNT_EN.
module demux_from_regs #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    demux_from_regs_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t        state [4];
    logic [W-1:0]       slot  [4];
    logic [3:0]         push;
    logic [3:0]         pop;
    logic               sel_rdy;

    // Input readiness looks only at the selected slot: free now, or being drained this cycle.
    always_comb begin
        sel_rdy = (state[bus.in_sel] == EMPTY) | bus.out_ready[bus.in_sel];
    end

    assign bus.in_ready = sel_rdy;

    // Decode the per-channel push and pop strobes for this cycle.
    always_comb begin
        push = '0;
        pop  = '0;
        push[bus.in_sel] = bus.in_valid & sel_rdy;
        for (int i = 0; i < 4; i++) begin
            pop[i] = (state[i] == FULL) & bus.out_ready[i];
        end
    end

    // Per-channel EMPTY/FULL slot FSM; a push in the same cycle as a pop reloads the slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state[i] <= EMPTY;
                slot[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                case (state[i])
                    EMPTY: begin
                        if (push[i]) begin
                            state[i] <= FULL;
                            slot[i]  <= bus.in_data;
                        end
                    end
                    FULL: begin
                        if (push[i]) begin
                            slot[i] <= bus.in_data;
                        end else if (pop[i]) begin
                            state[i] <= EMPTY;
                        end
                    end
                    default: state[i] <= EMPTY;
                endcase
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign bus.out_valid[g]          = (state[g] == FULL);
        assign bus.out_data[g*W +: W]    = slot[g];
    end

`ifdef DEMUX_FROM_REGS_CNT_EN
    logic [CNT_W-1:0] cnt [4];

    // Count delivered words per channel; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign bus.out_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end
`else
    assign bus.out_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_from_regs.sv
// Bench for demux_from_regs: table-driven routing vectors, directed corner sequences, random traffic.
// Reference model: one FIFO queue of accepted words per channel (capacity 1) plus delivery counts.
// Inputs change on the falling edge; outputs are sampled 1 time unit after either edge.
module tb_demux_from_regs;

    localparam int W     = 8;
    localparam int CNT_W = 8;

    logic clk;
    logic reset;

    demux_from_regs_if #(.W(W), .CNT_W(CNT_W)) bus ();

    demux_from_regs #(.W(W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Reference state: words accepted but not yet delivered, per channel, in order.
    logic [7:0]  q [4][$];
    int unsigned exp_cnt [4];
    int unsigned deliv [4];
    logic        last_rdy;

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] r;
        logic       exp_rdy;
        logic [3:0] exp_vld;
        logic [1:0] chk_ch;
        logic [7:0] chk_dat;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned cnt_expect(input int unsigned c);
`ifdef DEMUX_FROM_REGS_CNT_EN
        return c % (1 << CNT_W);
`else
        return 0;
`endif
    endfunction

    task automatic check_outputs();
        for (int i = 0; i < 4; i++) begin
            check("out_valid", bus.out_valid[i], (q[i].size() > 0) ? 1 : 0);
            if (q[i].size() > 0)
                check("out_data", bus.out_data[i*W +: W], q[i][0]);
            check("out_cnt", bus.out_cnt[i*CNT_W +: CNT_W], cnt_expect(exp_cnt[i]));
        end
    endtask

    // One clock cycle of stimulus, with the model advanced from the same inputs.
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
        logic exp_rdy;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = s;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        exp_rdy  = (q[s].size() == 0) || r[s];
        last_rdy = bus.in_ready;
        check("in_ready", bus.in_ready, exp_rdy);
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0 && r[i]) begin
                check("pop_data", bus.out_data[i*W +: W], q[i][0]);
                void'(q[i].pop_front());
                exp_cnt[i]++;
                deliv[i]++;
            end
        end
        if (v && exp_rdy)
            q[s].push_back(d);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_cnt", bus.out_cnt, 0);
        check("rst_out_data", bus.out_data, 0);
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            exp_cnt[i] = 0;
            deliv[i]   = 0;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d1;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sel    = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            exp_cnt[i] = 0;
            deliv[i]   = 0;
        end

        repeat (2) @(negedge clk);
        #1;
        check("init_out_valid", bus.out_valid, 0);
        check("init_out_cnt", bus.out_cnt, 0);
        check("init_out_data", bus.out_data, 0);
        @(negedge clk);
        reset = 1'b0;

        // Routing: fill all four channels with consumers stalled, then try to overfill ch2.
        tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001, 2'd0, 8'hA0};
        tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011, 2'd1, 8'hA1};
        tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111, 2'd2, 8'hA2};
        tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111, 2'd3, 8'hA3};
        tbl[4] = '{1'b1, 2'd2, 8'h55, 4'b0000, 1'b0, 4'b1111, 2'd2, 8'hA2};
        for (int k = 0; k < 5; k++) begin
            step(tbl[k].v, tbl[k].s, tbl[k].d, tbl[k].r);
            check("tbl_in_ready", last_rdy, tbl[k].exp_rdy);
            check("tbl_out_valid", bus.out_valid, tbl[k].exp_vld);
            check("tbl_ch_data", bus.out_data[tbl[k].chk_ch*W +: W], tbl[k].chk_dat);
        end

        // Reset asserted mid-cycle with all channels holding words.
        do_reset();
        #1;
        check("post_rst_out_valid", bus.out_valid, 0);

        // Throughput: 16 back-to-back words to ch1 with every consumer ready.
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 2'd1, k[7:0], 4'b1111);
            check("thru_in_ready", last_rdy, 1);
            check("thru_ch1_data", bus.out_data[1*W +: W], k);
        end
        step(1'b0, 2'd0, 8'h00, 4'b1111);
        check("thru_deliv_cnt", deliv[1], 16);
        check("thru_drained", bus.out_valid, 0);

        // Isolation: ch0 stalled must not block a push to ch3.
        do_reset();
        step(1'b1, 2'd0, 8'h33, 4'b0000);
        step(1'b1, 2'd3, 8'h77, 4'b0000);
        check("iso_in_ready", last_rdy, 1);
        check("iso_ch3_data", bus.out_data[3*W +: W], 8'h77);
        step(1'b0, 2'd0, 8'h00, 4'b1000);
        check("iso_ch0_held", bus.out_valid[0], 1);
        check("iso_ch0_data", bus.out_data[0*W +: W], 8'h33);
        check("iso_ch3_gone", bus.out_valid[3], 0);

        // Simultaneous pop and push on ch2 keeps the slot full.
        step(1'b1, 2'd2, 8'h11, 4'b0001);
        check("sim_ch2_first", bus.out_data[2*W +: W], 8'h11);
        d1 = deliv[2];
        step(1'b1, 2'd2, 8'h22, 4'b0100);
        check("sim_in_ready", last_rdy, 1);
        check("sim_popped", deliv[2] - d1, 1);
        check("sim_ch2_valid", bus.out_valid[2], 1);
        check("sim_ch2_data", bus.out_data[2*W +: W], 8'h22);
        step(1'b0, 2'd0, 8'h00, 4'b0100);
        check("sim_ch2_drained", bus.out_valid[2], 0);

        // Counter wrap: 257 deliveries on ch0.
        do_reset();
        for (int k = 0; k < 257; k++)
            step(1'b1, 2'd0, k[7:0], 4'b0001);
        step(1'b0, 2'd0, 8'h00, 4'b0001);
        check("wrap_deliv", deliv[0], 257);
        check("wrap_cnt0", bus.out_cnt[0 +: CNT_W], cnt_expect(257));
        check("wrap_cnt_others", bus.out_cnt[4*CNT_W-1:CNT_W], 0);

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
